// File: rtl/sevenseg_display.sv
// Four-digit multiplexed seven-segment driver for an MM:SS counter.
// Frame-coherent snapshot, per-slot refresh, and adjust-mode blinking.
module sevenseg_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min_first_dig,
  input  logic [3:0] min_second_dig,
  input  logic [3:0] sec_first_dig,
  input  logic [3:0] sec_second_dig,
  input  logic       adj,
  input  logic       sel,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [RW-1:0]     r_presc;
  logic [1:0]        r_idx;
  logic [3:0][3:0]   r_snap;
  logic [BW-1:0]     r_bcnt;
  logic              r_phase;

  logic              w_tick;
  logic              w_bwrap;
  logic [3:0]        w_dig;
  logic [6:0]        w_seg;
  logic [3:0]        w_an;
  logic              w_min_slot;
  logic              w_blank;

  assign w_tick  = (r_presc == RW'(REFRESH_DIV - 1));
  assign w_bwrap = (r_bcnt == BW'(BLINK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + RW'(1);
      if (w_tick) r_idx <= r_idx + 2'd1;
    end
  end

  // Latch a whole new frame only as the scan wraps back to the leftmost slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap <= '0;
    end else if (w_tick && r_idx == 2'd3) begin
      r_snap[0] <= min_first_dig;
      r_snap[1] <= min_second_dig;
      r_snap[2] <= sec_first_dig;
      r_snap[3] <= sec_second_dig;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_bcnt <= w_bwrap ? '0 : r_bcnt + BW'(1);
      if (w_bwrap) r_phase <= ~r_phase;
    end
  end

  assign w_dig      = r_snap[r_idx];
  assign w_min_slot = ~r_idx[1];
  assign w_blank    = adj & r_phase & (w_min_slot ^ sel);

  always_comb begin
    w_seg = 7'h3F;
    case (w_dig)
      4'd0: w_seg = 7'h40;
      4'd1: w_seg = 7'h79;
      4'd2: w_seg = 7'h24;
      4'd3: w_seg = 7'h30;
      4'd4: w_seg = 7'h19;
      4'd5: w_seg = 7'h12;
      4'd6: w_seg = 7'h02;
      4'd7: w_seg = 7'h78;
      4'd8: w_seg = 7'h00;
      4'd9: w_seg = 7'h10;
      default: w_seg = 7'h3F;
    endcase
  end

  always_comb begin
    w_an = 4'b1111;
    if (!w_blank) begin
      unique case (r_idx)
        2'd0: w_an = 4'b0111;
        2'd1: w_an = 4'b1011;
        2'd2: w_an = 4'b1101;
        2'd3: w_an = 4'b1110;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= 7'h7F;
      an  <= 4'b1111;
    end else begin
      seg <= w_seg;
      an  <= w_an;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_sevenseg_display.sv
// Bench for sevenseg_display: directed scenarios plus random stimulus
// checked against a cycle-count based reference model.
module tb_sevenseg_display;

  localparam int R = 4;
  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic       adj = 1'b0, sel = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sevenseg_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk),
    .rst(rst),
    .min_first_dig(d0),
    .min_second_dig(d1),
    .sec_first_dig(d2),
    .sec_second_dig(d3),
    .adj(adj),
    .sel(sel),
    .seg(seg),
    .an(an),
    .dp(dp)
  );

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Reference: k = clock edges since release. Slot = (k/R)%4,
  // blink phase = (k/B)%2, frame latched every 4*R edges.
  int         k;
  logic [3:0] m_snap [4];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  function automatic logic [3:0] f_an(input int kk, input logic a,
                                      input logic s);
    int idx;
    bit ph;
    idx = (kk / R) % 4;
    ph  = ((kk / B) % 2) == 1;
    if (a && ph && ((idx < 2) != s)) return 4'hF;
    return ~(4'b0001 << (3 - idx));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k       <= 0;
      m_snap  <= '{4'd0, 4'd0, 4'd0, 4'd0};
      exp_an  <= 4'hF;
      exp_seg <= 7'h7F;
    end else begin
      exp_an  <= f_an(k, adj, sel);
      exp_seg <= dec(m_snap[(k / R) % 4]);
      k       <= k + 1;
      if ((k + 1) % (4 * R) == 0) m_snap <= '{d0, d1, d2, d3};
    end
  end

  logic [3:0] ANS [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [6:0] S1234 [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
  logic [6:0] S5678 [4] = '{7'h12, 7'h02, 7'h78, 7'h00};

  task automatic do_reset(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] e,
                          input logic ad, input logic s);
    rst = 1'b0;
    d0 = a; d1 = b; d2 = c; d3 = e;
    adj = ad; sel = s;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
    adj = 1'b0; sel = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      fails++;
      $display("FAIL reset_hold an=%h seg=%h dp=%b exp F/7f/1", an, seg, dp);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (an !== 4'b0111 || seg !== 7'h40) begin
      fails++;
      $display("FAIL reset_first_edge an=%b seg=%h exp 0111/40", an, seg);
    end
    repeat (R - 1) @(posedge clk); #1;
    tests++;
    if (an !== 4'b0111) begin
      fails++;
      $display("FAIL first_tick_early an=%b exp 0111", an);
    end
    @(posedge clk); #1;
    tests++;
    if (an !== 4'b1011 || seg !== 7'h40) begin
      fails++;
      $display("FAIL first_tick an=%b seg=%h exp 1011/40", an, seg);
    end
  endtask

  task automatic test_scan;
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0);
    repeat (4 * R) @(posedge clk);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < R; c++) begin
        @(posedge clk); #1;
        tests++;
        if (an !== ANS[s] || seg !== S1234[s]) begin
          fails++;
          $display("FAIL scan slot%0d an=%b seg=%h exp %b/%h",
                   s, an, seg, ANS[s], S1234[s]);
        end
        tests++;
        if (an !== exp_an || seg !== exp_seg) begin
          fails++;
          $display("FAIL scan_model an=%b seg=%h exp %b/%h",
                   an, seg, exp_an, exp_seg);
        end
      end
    end
  endtask

  task automatic test_frame_change;
    int slot;
    logic [6:0] es;
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0);
    repeat (21) @(posedge clk); #1;
    d0 = 4'd5; d1 = 4'd6; d2 = 4'd7; d3 = 4'd8;
    for (int e = 22; e <= 48; e++) begin
      @(posedge clk); #1;
      slot = ((e - 1) / R) % 4;
      es = (e <= 32) ? S1234[slot] : S5678[slot];
      tests++;
      if (an !== ANS[slot] || seg !== es) begin
        fails++;
        $display("FAIL frame_change edge%0d an=%b seg=%h exp %b/%h",
                 e, an, seg, ANS[slot], es);
      end
    end
  endtask

  task automatic test_blink;
    int slot;
    bit ph;
    logic [3:0] ea;
    for (int s = 0; s < 2; s++) begin
      do_reset(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, s[0]);
      for (int e = 1; e <= 64; e++) begin
        @(posedge clk); #1;
        slot = ((e - 1) / R) % 4;
        ph = (((e - 1) / B) % 2) == 1;
        ea = (ph && ((slot < 2) != (s == 1))) ? 4'hF : ANS[slot];
        tests++;
        if (an !== ea || an !== exp_an || seg !== exp_seg) begin
          fails++;
          $display("FAIL blink sel%0d edge%0d an=%b seg=%h exp %b/%h",
                   s, e, an, seg, ea, exp_seg);
        end
      end
    end
  endtask

  task automatic test_dash;
    do_reset(4'hC, 4'(10 + $urandom_range(0, 5)),
             4'(10 + $urandom_range(0, 5)), 4'hF, 1'b0, 1'b0);
    repeat (4 * R) @(posedge clk);
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1;
      tests++;
      if (an !== ANS[s] || seg !== 7'h3F) begin
        fails++;
        $display("FAIL dash slot%0d an=%b seg=%h exp %b/3f",
                 s, an, seg, ANS[s]);
      end
      repeat (R - 1) @(posedge clk);
    end
  endtask

  task automatic test_random;
    do_reset(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'b0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      tests++;
      if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
        fails++;
        $display("FAIL random cyc%0d an=%b seg=%h dp=%b exp %b/%h/1",
                 n, an, seg, dp, exp_an, exp_seg);
      end
      if ($urandom_range(0, 7) == 0) d0 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) d1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) d2 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) d3 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) adj = ~adj;
      if ($urandom_range(0, 9) == 0) sel = ~sel;
    end
  endtask

  task automatic test_reset_midslot;
    adj = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      fails++;
      $display("FAIL async_reset an=%b seg=%h dp=%b exp 1111/7f/1",
               an, seg, dp);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (an !== 4'b0111 || seg !== 7'h40) begin
      fails++;
      $display("FAIL rerelease_first an=%b seg=%h exp 0111/40", an, seg);
    end
    repeat (R - 1) @(posedge clk); #1;
    tests++;
    if (an !== 4'b0111 || an !== exp_an) begin
      fails++;
      $display("FAIL rerelease_pre_tick an=%b exp 0111", an);
    end
    @(posedge clk); #1;
    tests++;
    if (an !== 4'b1011 || seg !== 7'h40) begin
      fails++;
      $display("FAIL rerelease_tick an=%b seg=%h exp 1011/40", an, seg);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_change();
    test_blink();
    test_dash();
    test_random();
    test_reset_midslot();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
